// File: rtl/phy_mgmt_arbiter.sv
// phy_mgmt_arbiter
//   Shares the PHY's single Wishbone management port between an external
//   master (e.g. an MDIO bridge) and an internal poller that reads one status
//   register every POLL_PERIOD cycles and exports the link state.
//
//   Optional feature macro: PHY_MGMT_TIMEOUT_EN
//     defined   -> a granted cycle is aborted after TIMEOUT cycles without
//                  ack/err and the owner sees a one-cycle error.
//     undefined -> a grant waits indefinitely for wb_ack/wb_err.
//
// Ports
//   clk, rst                 clock (clk_125 domain), synchronous active-high reset
//   ext_cyc/stb/we/addr/data_write   external master request
//   ext_ack/err/data_read    external termination, zero unless the master owns the bus
//   wb_cyc/stb/we/addr/data_write    to the PHY management slave
//   wb_ack/err/data_read     from the PHY management slave
//   link_up, bmsr            bit LINK_BIT / full data of the last successful poll
//   poll_valid, poll_error   one-cycle pulses after a poll ends with ack / err (or timeout)
//   poll_missed              one-cycle pulse when the timer expires with a poll still pending
module phy_mgmt_arbiter #(
  parameter int         POLL_PERIOD = 125000,
  parameter logic [4:0] POLL_ADDR   = 5'd1,
  parameter int         LINK_BIT    = 2,
  parameter int         TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_cyc,
  input  logic        ext_stb,
  input  logic        ext_we,
  input  logic [4:0]  ext_addr,
  input  logic [15:0] ext_data_write,
  output logic        ext_ack,
  output logic        ext_err,
  output logic [15:0] ext_data_read,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [15:0] wb_data_write,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic [15:0] wb_data_read,
  output logic        link_up,
  output logic [15:0] bmsr,
  output logic        poll_valid,
  output logic        poll_error,
  output logic        poll_missed
);

  localparam int TMW = $clog2(POLL_PERIOD);

  typedef enum logic [1:0] {IDLE, EXT, POLL} state_t;

  state_t         state, state_nxt;
  logic [TMW-1:0] timer;
  logic           poll_pending;
  logic           last_ext;     // last grant went to the external master
  logic           ext_req;
  logic           timer_zero;
  logic           to_hit;       // grant aborted this cycle for lack of a response
  logic           poll_ok, poll_fail;

  assign ext_req    = ext_cyc & ext_stb;
  assign timer_zero = (timer == '0);

`ifdef PHY_MGMT_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] to_cnt;

  // Zero throughout IDLE, so it reads 0 in the first granted cycle.
  always_ff @(posedge clk) begin
    if (rst)                          to_cnt <= '0;
    else if (state == IDLE)           to_cnt <= '0;
    else if (to_cnt != TOW'(TIMEOUT)) to_cnt <= to_cnt + TOW'(1);
  end

  // A response arriving in the deadline cycle still wins.
  assign to_hit = (state != IDLE) && (to_cnt == TOW'(TIMEOUT)) && !wb_ack && !wb_err;
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    wb_cyc        = 1'b0;
    wb_stb        = 1'b0;
    wb_we         = 1'b0;
    wb_addr       = '0;
    wb_data_write = '0;
    ext_ack       = 1'b0;
    ext_err       = 1'b0;
    ext_data_read = '0;
    poll_ok       = 1'b0;
    poll_fail     = 1'b0;
    case (state)
      IDLE: begin
        // Contention goes to whoever was not served last.
        if (ext_req && poll_pending) state_nxt = last_ext ? POLL : EXT;
        else if (poll_pending)       state_nxt = POLL;
        else if (ext_req)            state_nxt = EXT;
      end
      EXT: begin
        wb_cyc        = ext_cyc & ~to_hit;
        wb_stb        = ext_stb & ~to_hit;
        wb_we         = ext_we;
        wb_addr       = ext_addr;
        wb_data_write = ext_data_write;
        ext_ack       = wb_ack;
        ext_err       = wb_err | to_hit;
        ext_data_read = wb_data_read;
        // An abandoned cycle releases the bus immediately, without termination.
        if (!ext_cyc || wb_ack || wb_err || to_hit) state_nxt = IDLE;
      end
      POLL: begin
        wb_cyc  = ~to_hit;
        wb_stb  = ~to_hit;
        wb_addr = POLL_ADDR;
        // err dominates a simultaneous ack
        if (wb_err || to_hit) poll_fail = 1'b1;
        else if (wb_ack)      poll_ok   = 1'b1;
        if (wb_ack || wb_err || to_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completing poll cancels the miss; the expiry then re-arms pending.
  assign poll_missed = timer_zero & poll_pending & ~(poll_ok | poll_fail);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= TMW'(POLL_PERIOD - 1);
      poll_pending <= 1'b0;
      last_ext     <= 1'b0;
      link_up      <= 1'b0;
      bmsr         <= '0;
      poll_valid   <= 1'b0;
      poll_error   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_zero ? TMW'(POLL_PERIOD - 1) : timer - TMW'(1);
      if (timer_zero)                poll_pending <= 1'b1;
      else if (poll_ok || poll_fail) poll_pending <= 1'b0;
      if (state == IDLE && state_nxt != IDLE) last_ext <= (state_nxt == EXT);
      poll_valid <= poll_ok;
      poll_error <= poll_fail;
      if (poll_ok) begin
        bmsr    <= wb_data_read;
        link_up <= wb_data_read[LINK_BIT];
      end
    end
  end

endmodule

// File: tb/tb_phy_mgmt_arbiter.sv
// Bench for phy_mgmt_arbiter: directed scenarios plus a randomized run,
// with a background transaction-level model checking grants, bus driving,
// poll results and missed-poll pulses every cycle.
module tb_phy_mgmt_arbiter;
  localparam int         P     = 16;
  localparam logic [4:0] PADDR = 5'd1;
  localparam int         LB    = 2;
  localparam int         TO    = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ext_cyc = 0, ext_stb = 0, ext_we = 0;
  logic [4:0]  ext_addr = '0;
  logic [15:0] ext_data_write = '0;
  logic        ext_ack, ext_err;
  logic [15:0] ext_data_read;
  logic        wb_cyc, wb_stb, wb_we;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data_write;
  logic        wb_ack = 0, wb_err = 0;
  logic [15:0] wb_data_read = '0;
  logic        link_up;
  logic [15:0] bmsr;
  logic        poll_valid, poll_error, poll_missed;

  phy_mgmt_arbiter #(.POLL_PERIOD(P), .POLL_ADDR(PADDR), .LINK_BIT(LB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ext_cyc(ext_cyc), .ext_stb(ext_stb), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_data_write(ext_data_write), .ext_ack(ext_ack), .ext_err(ext_err),
    .ext_data_read(ext_data_read),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data_write(wb_data_write), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_data_read(wb_data_read),
    .link_up(link_up), .bmsr(bmsr), .poll_valid(poll_valid), .poll_error(poll_error),
    .poll_missed(poll_missed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;           // cycles since reset release
  bit mon_en = 1'b1;

  // ---------------- slave model ----------------
  // mode 0: ack after slv_delay extra cycles; 1: err; 2: silent; 3: random
  int          slv_mode = 0, slv_delay = 0;
  logic [15:0] slv_data = '0;
  int          scnt = 0, cur_delay = 0;
  bit          cur_err = 0;

  initial forever begin
    @(posedge clk); #2;
    if (wb_cyc && wb_stb) begin
      scnt++;
      if (scnt == 1) begin
        cur_delay    = (slv_mode == 3) ? int'($urandom_range(0, 4)) : slv_delay;
        cur_err      = (slv_mode == 1) || (slv_mode == 3 && $urandom_range(0, 7) == 0);
        wb_data_read = (slv_mode == 3) ? 16'($urandom) : slv_data;
      end
      if (slv_mode != 2 && scnt > cur_delay) begin
        wb_ack = !cur_err; wb_err = cur_err;
      end else begin
        wb_ack = 0; wb_err = 0;
      end
    end else begin
      scnt = 0; wb_ack = 0; wb_err = 0;
    end
  end

  // ---------------- reference model / monitor ----------------
  bit          m_pend, m_pp_prev, m_pe_prev, m_last_ext, m_prev_cyc, m_owner_ext;
  logic [15:0] m_bmsr;
  bit          exp_valid, exp_error, exp_own, obs_ext, pdone, expiry, exp_miss;

  initial forever begin
    @(negedge clk);
    if (rst || !mon_en) begin
      cyc = 0; m_pend = 0; m_pp_prev = 0; m_pe_prev = 0; m_last_ext = 0;
      m_prev_cyc = 0; m_owner_ext = 0; m_bmsr = '0; exp_valid = 0; exp_error = 0;
    end else begin
      n_cmp++;
      if (poll_valid !== exp_valid || poll_error !== exp_error) begin
        n_err++;
        $display("FAIL poll_pulse cyc=%0d got v=%b e=%b want v=%b e=%b", cyc, poll_valid, poll_error, exp_valid, exp_error);
      end
      n_cmp++;
      if (bmsr !== m_bmsr || link_up !== m_bmsr[LB]) begin
        n_err++;
        $display("FAIL status cyc=%0d got bmsr=%h link=%b want bmsr=%h", cyc, bmsr, link_up, m_bmsr);
      end
      // A cycle without wb_cyc is an arbitration cycle: any request there must be served next.
      if (!m_prev_cyc && (m_pe_prev || m_pp_prev)) begin
        exp_own = (m_pe_prev && m_pp_prev) ? !m_last_ext : m_pe_prev;
        obs_ext = !(wb_addr == PADDR && !wb_we);
        n_cmp++;
        if (wb_cyc !== 1'b1 || obs_ext != exp_own) begin
          n_err++;
          $display("FAIL grant cyc=%0d got cyc=%b ext=%b want ext=%b", cyc, wb_cyc, obs_ext, exp_own);
        end
        m_last_ext = exp_own; m_owner_ext = exp_own;
      end else if (wb_cyc && !m_prev_cyc) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_grant cyc=%0d got wb_cyc=1 want 0", cyc);
      end
      n_cmp++;
      if (wb_cyc) begin
        if (m_owner_ext) begin
          if (wb_addr !== ext_addr || wb_we !== ext_we || wb_data_write !== ext_data_write ||
              ext_ack !== wb_ack || ext_err !== wb_err || ext_data_read !== wb_data_read) begin
            n_err++;
            $display("FAIL ext_mirror cyc=%0d got addr=%h ack=%b rd=%h want addr=%h ack=%b rd=%h",
                     cyc, wb_addr, ext_ack, ext_data_read, ext_addr, wb_ack, wb_data_read);
          end
        end else if (wb_we !== 0 || wb_addr !== PADDR || wb_data_write !== 0 ||
                     ext_ack !== 0 || ext_err !== 0 || ext_data_read !== 0) begin
          n_err++;
          $display("FAIL poll_drive cyc=%0d got we=%b addr=%h ext_ack=%b want we=0 addr=%h ext_ack=0",
                   cyc, wb_we, wb_addr, ext_ack, PADDR);
        end
      end else if (ext_ack !== 0 || ext_err !== 0 || ext_data_read !== 0) begin
        n_err++;
        $display("FAIL idle_ext_out cyc=%0d got ack=%b err=%b rd=%h want 0", cyc, ext_ack, ext_err, ext_data_read);
      end
      pdone    = wb_cyc && !m_owner_ext && (wb_ack || wb_err);
      expiry   = (cyc % P) == (P - 1);
      exp_miss = expiry && m_pend && !pdone;
      n_cmp++;
      if (poll_missed !== exp_miss) begin
        n_err++;
        $display("FAIL poll_missed cyc=%0d got %b want %b", cyc, poll_missed, exp_miss);
      end
      exp_valid = pdone && !wb_err;
      exp_error = pdone && wb_err;
      if (exp_valid) m_bmsr = wb_data_read;
      m_pp_prev = m_pend;
      if (pdone)  m_pend = 0;
      if (expiry) m_pend = 1;
      m_pe_prev  = ext_cyc && ext_stb;
      m_prev_cyc = wb_cyc;
      cyc++;
    end
  end

  // ---------------- helpers and scenarios ----------------
  task automatic do_reset();
    rst = 1; ext_cyc = 0; ext_stb = 0; ext_we = 0; ext_addr = '0; ext_data_write = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic ext_drive(input logic [4:0] a, input logic we, input logic [15:0] d);
    ext_cyc = 1; ext_stb = 1; ext_addr = a; ext_we = we; ext_data_write = d;
  endtask

  task automatic ext_drop();
    ext_cyc = 0; ext_stb = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (wb_cyc !== 0 || wb_stb !== 0 || wb_we !== 0 || wb_addr !== 0 || wb_data_write !== 0) begin
      n_err++; $display("FAIL reset_wb got cyc=%b stb=%b addr=%h want 0", wb_cyc, wb_stb, wb_addr);
    end
    n_cmp++;
    if (link_up !== 0 || bmsr !== 0 || poll_valid !== 0 || poll_error !== 0 || poll_missed !== 0) begin
      n_err++; $display("FAIL reset_status got link=%b bmsr=%h v=%b e=%b m=%b want 0",
                        link_up, bmsr, poll_valid, poll_error, poll_missed);
    end
    n_cmp++;
    if (ext_ack !== 0 || ext_err !== 0 || ext_data_read !== 0) begin
      n_err++; $display("FAIL reset_ext got ack=%b err=%b rd=%h want 0", ext_ack, ext_err, ext_data_read);
    end
  endtask

  task automatic test_first_poll();
    int t = -1;
    slv_mode = 0; slv_delay = 0; slv_data = 16'h782D;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (poll_valid) begin t = i; break; end
    end
    n_cmp++;
    if (t != P + 2) begin n_err++; $display("FAIL first_poll_cycle got %0d want %0d", t, P + 2); end
    n_cmp++;
    if (bmsr !== 16'h782D || link_up !== 1'b1) begin
      n_err++; $display("FAIL first_poll_data got bmsr=%h link=%b want 782d 1", bmsr, link_up);
    end
  endtask

  task automatic test_ext_read();
    slv_mode = 0; slv_delay = 1; slv_data = 16'hA5C3;
    do_reset();
    @(posedge clk); #1;
    ext_drive(5'd2, 1'b0, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (wb_cyc !== 0) begin n_err++; $display("FAIL ext_latency_n got wb_cyc=%b want 0", wb_cyc); end
    @(negedge clk);
    n_cmp++;
    if (wb_cyc !== 1 || wb_addr !== 5'd2 || wb_we !== 0) begin
      n_err++; $display("FAIL ext_latency_n1 got cyc=%b addr=%h want 1 02", wb_cyc, wb_addr);
    end
    for (int i = 0; i < 20 && !ext_ack; i++) @(negedge clk);
    n_cmp++;
    if (ext_ack !== 1 || ext_data_read !== 16'hA5C3) begin
      n_err++; $display("FAIL ext_read got ack=%b rd=%h want 1 a5c3", ext_ack, ext_data_read);
    end
    @(posedge clk); #1;
    ext_drop();
  endtask

  // Follows test_ext_read: the external master was served last.
  task automatic test_round_robin();
    int idle = 0;
    n_cmp++;
    if (cyc >= P) begin n_err++; $display("FAIL rr_setup got cyc=%0d want <%0d", cyc, P); end
    for (int i = 0; i < 40 && cyc != P; i++) begin @(posedge clk); #1; end
    ext_drive(5'd7, 1'b1, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (wb_cyc !== 1 || wb_addr !== PADDR || wb_we !== 0) begin
      n_err++; $display("FAIL rr_poll_first got cyc=%b addr=%h we=%b want 1 %h 0", wb_cyc, wb_addr, wb_we, PADDR);
    end
    for (int i = 0; i < 20 && wb_cyc; i++) @(negedge clk);
    for (int i = 0; i < 20 && !wb_cyc; i++) begin idle++; @(negedge clk); end
    n_cmp++;
    if (idle != 1 || wb_addr !== 5'd7 || wb_we !== 1 || wb_data_write !== 16'h1234) begin
      n_err++; $display("FAIL rr_ext_second got idle=%0d addr=%h we=%b want 1 07 1", idle, wb_addr, wb_we);
    end
    for (int i = 0; i < 20 && !ext_ack; i++) @(negedge clk);
    @(posedge clk); #1;
    ext_drop();
  endtask

  task automatic test_missed();
    int rises = 0, miss = 0;
    bit prev = 0;
    slv_mode = 0; slv_delay = 40; slv_data = 16'h0004;
    do_reset();
    for (int i = 0; i < 61; i++) begin
      @(negedge clk);
      if (wb_cyc && !prev) rises++;
      if (poll_missed) miss++;
      prev = wb_cyc;
    end
    n_cmp++;
    if (rises != 1) begin n_err++; $display("FAIL missed_single_poll got %0d polls want 1", rises); end
    n_cmp++;
    if (miss < 1) begin n_err++; $display("FAIL missed_pulse got %0d want >=1", miss); end
    // reset while the next poll is outstanding
    slv_mode = 2;
    for (int i = 0; i < 20 && !wb_cyc; i++) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (wb_cyc !== 0 || wb_stb !== 0 || poll_valid !== 0 || poll_error !== 0) begin
      n_err++; $display("FAIL mid_reset got cyc=%b stb=%b v=%b e=%b want 0", wb_cyc, wb_stb, poll_valid, poll_error);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_poll_err();
    bit seen = 0;
    slv_mode = 0; slv_delay = 0; slv_data = 16'h782D;
    do_reset();
    for (int i = 0; i < 40 && !poll_valid; i++) @(negedge clk);
    slv_mode = 1; slv_data = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (poll_error) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen || poll_valid !== 0) begin
      n_err++; $display("FAIL poll_err_pulse got seen=%b v=%b want 1 0", seen, poll_valid);
    end
    n_cmp++;
    if (bmsr !== 16'h782D || link_up !== 1) begin
      n_err++; $display("FAIL poll_err_hold got bmsr=%h link=%b want 782d 1", bmsr, link_up);
    end
  endtask

  task automatic test_random();
    int done = 0, n;
    slv_mode = 3;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if (!ext_cyc) begin
        n = $urandom_range(0, 6);
        if (n > 0) begin repeat (n) @(posedge clk); #1; end
      end
      ext_drive(5'($urandom_range(2, 31)), 1'($urandom), 16'($urandom));
      for (int i = 0; i < 200 && !(ext_ack || ext_err); i++) @(negedge clk);
      if (ext_ack || ext_err) done++;
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 0) ext_drop();
    end
    ext_drop();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (done != 40) begin n_err++; $display("FAIL random_completions got %0d want 40", done); end
  endtask

`ifdef PHY_MGMT_TIMEOUT_EN
  task automatic test_timeout();
    int t = 0;
    mon_en = 0; slv_mode = 2;
    do_reset();
    ext_drive(5'd3, 1'b0, 16'h0);
    for (int i = 0; i < 5 && !wb_cyc; i++) @(negedge clk);
    for (int i = 0; i < 20 && !ext_err; i++) begin @(negedge clk); t++; end
    n_cmp++;
    if (t != TO || ext_err !== 1 || wb_cyc !== 0) begin
      n_err++; $display("FAIL timeout got t=%0d err=%b cyc=%b want %0d 1 0", t, ext_err, wb_cyc, TO);
    end
    @(posedge clk); #1;
    ext_drop();
    @(negedge clk);
    n_cmp++;
    if (ext_err !== 0 || wb_cyc !== 0) begin
      n_err++; $display("FAIL timeout_idle got err=%b cyc=%b want 0 0", ext_err, wb_cyc);
    end
    mon_en = 1;
    do_reset();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_poll();
    test_ext_read();
    test_round_robin();
    test_missed();
    test_poll_err();
    test_random();
`ifdef PHY_MGMT_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
